// File: rtl/dmem_pkg.sv
// Shared types and helpers for the multi-cycle data-memory responder.
package dmem_pkg;

    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // Flags a misaligned byte address or a word index beyond the array.
    function automatic logic addr_err(input logic [WORD_W-1:0] addr, input int unsigned depth);
        return (addr[1:0] != 2'b00) || (addr[WORD_W-1:2] >= 30'(depth));
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word RAM: synchronous write, combinational read, contents survive reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  widx,
    input  logic [WORD_W-1:0] wdata,
    input  logic [IDX_W-1:0]  ridx,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[widx] <= wdata;
        end
    end

    assign rdata = mem_q[ridx];

endmodule

// File: rtl/dmem_responder.sv
// Valid/ready data-memory target with a fixed number of wait states per access.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    localparam int unsigned IDX_W    = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    dmem_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              write_q;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic              resp_valid_q;
    logic [WORD_W-1:0] resp_rdata_q;
    logic              resp_err_q;

    logic              accept;
    logic              commit;
    logic              cur_write;
    logic [WORD_W-1:0] cur_addr;
    logic [WORD_W-1:0] cur_wdata;
    logic              cur_err;
    logic [IDX_W-1:0]  cur_idx;
    logic [WORD_W-1:0] mem_rdata;

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign accept    = req_valid && req_ready;

    // With zero wait states the commit edge is the accept edge, so use the live request.
    assign cur_write = req_ready ? req_write : write_q;
    assign cur_addr  = req_ready ? req_addr  : addr_q;
    assign cur_wdata = req_ready ? req_wdata : wdata_q;
    assign cur_err   = addr_err(cur_addr, DEPTH_WORDS);
    assign cur_idx   = cur_addr[IDX_W+1:2];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cnt_d = CNT_INIT;
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                    end else begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (resp_valid_q && resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request is captured only on the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else if (commit) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= cur_err;
            resp_rdata_q <= (cur_write || cur_err) ? '0 : mem_rdata;
        end else if (state_q == RESP && resp_valid_q && resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    dmem_array #(
        .DEPTH (DEPTH_WORDS),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (commit && cur_write && !cur_err),
        .widx  (cur_idx),
        .wdata (cur_wdata),
        .ridx  (cur_idx),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with 2 wait states, one with none.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 256;

    logic clk;
    logic rst_n;

    logic        a_req_valid, a_req_ready, a_req_write;
    logic [31:0] a_req_addr, a_req_wdata;
    logic        a_resp_valid, a_resp_ready, a_resp_err, a_busy;
    logic [31:0] a_resp_rdata;

    logic        b_req_valid, b_req_ready, b_req_write;
    logic [31:0] b_req_addr, b_req_wdata;
    logic        b_resp_valid, b_resp_ready, b_resp_err, b_busy;
    logic [31:0] b_resp_rdata;

    int n_checks = 0;
    int n_errors = 0;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2)) u_dut_w2 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
        .resp_rdata(a_resp_rdata), .resp_err(a_resp_err), .busy(a_busy)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
        .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One full transaction; lat counts edges from the cycle the request is presented.
    task automatic txn(input bit sel, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd,
                       output logic er, output int lat);
        @(negedge clk);
        if (sel) begin
            b_req_valid = 1'b1; b_req_write = wr; b_req_addr = addr; b_req_wdata = wd;
        end else begin
            a_req_valid = 1'b1; a_req_write = wr; a_req_addr = addr; a_req_wdata = wd;
        end
        @(posedge clk); #1;
        lat = 1;
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        while (((sel ? b_resp_valid : a_resp_valid) == 1'b0) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = sel ? b_resp_rdata : a_resp_rdata;
        er = sel ? b_resp_err : a_resp_err;
        if (sel) b_resp_ready = 1'b1; else a_resp_ready = 1'b1;
        @(posedge clk); #1;
        a_resp_ready = 1'b0;
        b_resp_ready = 1'b0;
    endtask

    logic [31:0] rd, snap_rd;
    logic        er, snap_er;
    int          lat;
    logic [31:0] vals [3];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        a_req_valid = 0; a_req_write = 0; a_req_addr = 0; a_req_wdata = 0; a_resp_ready = 0;
        b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_wdata = 0; b_resp_ready = 0;
        vals[0] = 32'h0102_0304; vals[1] = 32'hCAFE_F00D; vals[2] = 32'h1234_5678;
        repeat (2) @(posedge clk);
        #1;
        check("rst_resp_valid", 32'(a_resp_valid), 32'd0);
        check("rst_resp_rdata", a_resp_rdata, 32'd0);
        check("rst_resp_err",   32'(a_resp_err), 32'd0);
        check("rst_req_ready",  32'(a_req_ready), 32'd1);
        check("rst_busy",       32'(a_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Store then load with two wait states.
        txn(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, rd, er, lat);
        check("w2_store_lat", 32'(lat), 32'd3);
        check("w2_store_rdata", rd, 32'd0);
        check("w2_store_err", 32'(er), 32'd0);
        check("w2_after_hs_valid", 32'(a_resp_valid), 32'd0);
        check("w2_after_hs_ready", 32'(a_req_ready), 32'd1);
        txn(1'b0, 1'b0, 32'h10, 32'h0, rd, er, lat);
        check("w2_load_lat", 32'(lat), 32'd3);
        check("w2_load_rdata", rd, 32'hDEAD_BEEF);
        check("w2_load_err", 32'(er), 32'd0);

        // Reset mid-WAIT drops a pending store.
        txn(1'b0, 1'b1, 32'h30, 32'h1111_1111, rd, er, lat);
        @(negedge clk);
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'h30; a_req_wdata = 32'h2222_2222;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        check("midwait_busy", 32'(a_busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_resp_valid", 32'(a_resp_valid), 32'd0);
        check("midrst_resp_rdata", a_resp_rdata, 32'd0);
        check("midrst_resp_err",   32'(a_resp_err), 32'd0);
        check("midrst_req_ready",  32'(a_req_ready), 32'd1);
        check("midrst_busy",       32'(a_busy), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        check("midrst_stays_idle", 32'(a_resp_valid), 32'd0);
        txn(1'b0, 1'b0, 32'h30, 32'h0, rd, er, lat);
        check("midrst_old_value", rd, 32'h1111_1111);

        // Error cases.
        txn(1'b0, 1'b0, 32'h13, 32'h0, rd, er, lat);
        check("misal_load_err", 32'(er), 32'd1);
        check("misal_load_rdata", rd, 32'd0);
        txn(1'b0, 1'b0, DEPTH * 4, 32'h0, rd, er, lat);
        check("oor_load_err", 32'(er), 32'd1);
        check("oor_load_rdata", rd, 32'd0);
        txn(1'b0, 1'b1, 32'h20, 32'hA5A5_A5A5, rd, er, lat);
        txn(1'b0, 1'b1, 32'h22, 32'h5A5A_5A5A, rd, er, lat);
        check("misal_store_err", 32'(er), 32'd1);
        txn(1'b0, 1'b0, 32'h20, 32'h0, rd, er, lat);
        check("misal_store_nowrite", rd, 32'hA5A5_A5A5);

        // Back-pressure: response held, second request refused.
        @(negedge clk);
        a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 32'h10;
        @(posedge clk); #1;
        a_req_addr = 32'h20;
        lat = 1;
        while (!a_resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_lat", 32'(lat), 32'd3);
        snap_rd = a_resp_rdata;
        snap_er = a_resp_err;
        check("bp_rdata", snap_rd, 32'hDEAD_BEEF);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_valid_held", 32'(a_resp_valid), 32'd1);
            check("bp_rdata_held", a_resp_rdata, snap_rd);
            check("bp_err_held", 32'(a_resp_err), 32'(snap_er));
            check("bp_req_ready_low", 32'(a_req_ready), 32'd0);
        end
        a_req_valid = 1'b0;
        a_resp_ready = 1'b1;
        @(posedge clk); #1;
        a_resp_ready = 1'b0;
        check("bp_hs_rdata_clr", a_resp_rdata, 32'd0);
        @(posedge clk); #1;
        check("bp_no_second_accept", 32'(a_busy), 32'd0);

        // Last word boundary.
        txn(1'b0, 1'b1, (DEPTH - 1) * 4, 32'hFFFF_FFFF, rd, er, lat);
        check("last_store_err", 32'(er), 32'd0);
        txn(1'b0, 1'b0, (DEPTH - 1) * 4, 32'h0, rd, er, lat);
        check("last_load_rdata", rd, 32'hFFFF_FFFF);
        check("last_load_err", 32'(er), 32'd0);

        // Zero wait states: preload, then back-to-back loads.
        for (int i = 0; i < 3; i++) begin
            txn(1'b1, 1'b1, 32'h40 + 32'(i * 4), vals[i], rd, er, lat);
            check("w0_store_lat", 32'(lat), 32'd1);
        end
        @(negedge clk);
        b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 32'h40; b_resp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check("w0_b2b_valid", 32'(b_resp_valid), (k % 2 == 0) ? 32'd1 : 32'd0);
            if (k % 2 == 0) begin
                check("w0_b2b_rdata", b_resp_rdata, vals[k / 2]);
                b_req_addr = 32'h44 + 32'(k * 2);
            end
        end
        b_req_valid = 1'b0;
        b_resp_ready = 1'b0;
        @(posedge clk); #1;
        check("w0_idle_end", 32'(b_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
